// File: rtl/da_fir_param.sv
`default_nettype none
// ============================================================================
// Module   : da_fir_param
// Purpose  : Parametrised bit-serial distributed-arithmetic FIR engine.
//            Owns a TAPS-deep sample delay line and N_GROUPS coefficient
//            LUT banks (2^K entries each, loaded over a write port). Each
//            accepted sample is followed by DATA_W bit-slice cycles; the
//            result is presented on y_out with a one-cycle y_valid pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   single clock
//   resetn      in   asynchronous active-low reset
//   cload       in   LUT write strobe (only honoured while idle)
//   caddr       in   {bank, entry} LUT write address
//   cin         in   signed LUT write data
//   x_in        in   input sample
//   x_valid     in   sample offered
//   x_ready     out  engine can accept a sample this cycle
//   signed_mode in   samples are two's complement (sampled on accept)
//   y_out       out  signed filter result, held until the next result
//   y_valid     out  one-cycle pulse marking a new y_out
// ============================================================================
module da_fir_param #(
  parameter int N_GROUPS = 8,
  parameter int K        = 8,
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 20,
  parameter int ACC_W    = 38
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           cload,
  input  logic [$clog2(N_GROUPS)+K-1:0]  caddr,
  input  logic [COEF_W-1:0]              cin,
  input  logic [DATA_W-1:0]              x_in,
  input  logic                           x_valid,
  output logic                           x_ready,
  input  logic                           signed_mode,
  output logic [ACC_W-1:0]               y_out,
  output logic                           y_valid
);

  localparam int TAPS  = N_GROUPS * K;
  localparam int G_W   = $clog2(N_GROUPS);
  localparam int CA_W  = G_W + K;
  localparam int PS_W  = COEF_W + G_W;          // width of the per-slice bank sum
  localparam int B_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DEPTH = 1 << K;

  localparam logic [B_W-1:0] B_LAST  = B_W'(DATA_W - 1);
  localparam logic [G_W:0]   GRP_LIM = (G_W + 1)'(N_GROUPS);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CALC = 1'b1;

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  logic [0:0]        state_q, state_d;
  logic [B_W-1:0]    b_q, b_d;
  logic [DATA_W-1:0] tap_q [TAPS];
  logic [DATA_W-1:0] tap_d [TAPS];
  logic              smode_q, smode_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  y_out_q, y_out_d;
  logic              y_valid_q, y_valid_d;

  // Coefficient banks: plain synchronous-write storage with no reset, so the
  // contents survive resetn and map onto distributed RAM.
  logic [COEF_W-1:0] lut_mem [N_GROUPS][DEPTH];

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic              accept;
  logic              last_slice;
  logic              lut_we;
  logic [G_W-1:0]    wr_bank;
  logic [K-1:0]      wr_idx;
  logic [K-1:0]      bank_addr [N_GROUPS];
  logic [COEF_W-1:0] bank_rd   [N_GROUPS];
  logic [PS_W-1:0]   partial;
  logic [ACC_W-1:0]  term;
  logic [ACC_W-1:0]  acc_next;

  assign wr_bank = caddr[CA_W-1:K];
  assign wr_idx  = caddr[K-1:0];

  assign accept     = x_valid & x_ready;
  assign last_slice = (state_q == S_CALC) && (b_q == B_LAST);

  // Writes are only honoured while idle; a bank index past the last bank
  // (possible when N_GROUPS is not a power of two) is dropped.
  assign lut_we = (state_q == S_IDLE) && cload && ({1'b0, wr_bank} < GRP_LIM);

  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut_mem[wr_bank][wr_idx] <= cin;
    end
  end

  // Bank g is addressed by bit b of its K taps: address bit j comes from
  // tap[g*K + j].
  always_comb begin
    for (int g = 0; g < N_GROUPS; g++) begin
      bank_addr[g] = '0;
      for (int j = 0; j < K; j++) begin
        bank_addr[g][j] = tap_q[g*K + j][b_q];
      end
      bank_rd[g] = lut_mem[g][bank_addr[g]];
    end
  end

  // Adder tree over all banks, each entry sign-extended so the sum of
  // N_GROUPS signed COEF_W values cannot overflow.
  always_comb begin
    partial = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      partial = partial + {{G_W{bank_rd[g][COEF_W-1]}}, bank_rd[g]};
    end
  end

  // Weight the slice by 2^b. In signed mode the MSB slice carries negative
  // weight, which is what turns the unsigned bit-serial sum into a
  // two's-complement product.
  assign term     = {{(ACC_W - PS_W){partial[PS_W-1]}}, partial} << b_q;
  assign acc_next = (smode_q && (b_q == B_LAST)) ? (acc_q - term) : (acc_q + term);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)     state_d = S_CALC;
      S_CALC:  if (last_slice) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. cload has priority over a waiting sample while idle.
  // --------------------------------------------------------------------------
  always_comb begin
    x_ready = 1'b0;
    case (state_q)
      S_IDLE:  x_ready = ~cload;
      default: x_ready = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    tap_d     = tap_q;
    smode_d   = smode_q;
    acc_d     = acc_q;
    b_d       = b_q;
    y_out_d   = y_out_q;
    y_valid_d = 1'b0;

    if (accept) begin
      tap_d[0] = x_in;
      for (int i = 1; i < TAPS; i++) begin
        tap_d[i] = tap_q[i-1];
      end
      smode_d = signed_mode;
      acc_d   = '0;
      b_d     = '0;
    end else if (state_q == S_CALC) begin
      acc_d = acc_next;
      b_d   = b_q + B_W'(1);
      if (last_slice) begin
        y_out_d   = acc_next;
        y_valid_d = 1'b1;
        b_d       = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TAPS; i++) begin
        tap_q[i] <= '0;
      end
      smode_q   <= 1'b0;
      acc_q     <= '0;
      b_q       <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        tap_q[i] <= tap_d[i];
      end
      smode_q   <= smode_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;

endmodule
`default_nettype wire
